branch_recovery: RTL and testbench
==================================

# branch_recovery

Pipeline recovery stage directly downstream of the branch resolution unit. Holds a queue of fall-through PCs for branches predicted taken at decode. It pops one entry each time execute resolves a branch. On `branch_fail_i` it redirects fetch to the stored fall-through PC and squashes the wrong-path instructions for a fixed number of cycles.

## Interface
- `DEPTH`, 4: number of in-flight predicted branches held; power of two, ≥2.
- `PC_W`, 16: PC width (XM23 word-aligned addresses).
- `FLUSH_CYCLES`, 2: cycles `squash_o` stays high after a redirect; ≥1.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `push_i`  in  1  decode enqueues a predicted-taken branch this cycle.
- `push_pc_i`  in  PC_W  fall-through PC (branch PC + 2) of the pushed branch.
- `resolve_i`  in  1  execute resolves the oldest queued branch this cycle.
- `branch_fail_i`  in  1  qualified by `resolve_i`: the prediction was wrong.
- `stall_o`  out  1  queue full; decode must hold its branch (combinational from count).
- `redirect_o`  out  1  one-cycle pulse: load fetch PC from `redirect_pc_o`.
- `redirect_pc_o`  out  PC_W  recovery PC; valid while `redirect_o` is high, otherwise holds its last value.
- `squash_o`  out  1  convert fetch/decode stage contents to NOPs.
- `count_o`  out  $clog2(DEPTH)+1  number of occupied entries.
- `error_o`  out  1  sticky: resolve was seen while the queue was empty; cleared only by reset.

## Operation
- FSM states: `IDLE` and `FLUSH`.
- `IDLE`:
  - `push_i` with the queue not full writes `push_pc_i` at the tail.
  - `resolve_i` pops the head.
  - Push and resolve in the same cycle both take effect; count is unchanged.
- Correct resolution (`resolve_i=1`, `branch_fail_i=0`): pop only; no other output changes.
- Failed resolution (`resolve_i=1`, `branch_fail_i=1`):
  - Latch the head PC into `redirect_pc_o`.
  - Clear the whole queue. Younger entries are wrong-path. A same-cycle push is discarded.
  - Go to `FLUSH` with the flush counter set to `FLUSH_CYCLES-1`.
- `FLUSH`:
  - `squash_o` is high.
  - `push_i` and `resolve_i` are ignored.
  - The counter decrements each cycle; at 0, return to `IDLE`.
- `push_i` while full: no write and no count change. Decode must respect `stall_o`.
- `resolve_i` while empty: no pop, no redirect, `error_o` set.
- `branch_fail_i` without `resolve_i`: ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Fullness comes from `count_o`, not from pointer comparison.

## Timing
- Reset values: state `IDLE`, pointers 0, `count_o`=0, `stall_o`=0, `redirect_o`=0, `redirect_pc_o`=0, `squash_o`=0, `error_o`=0, flush counter 0.
- Push to visible entry: one cycle (`count_o` increments the cycle after the push edge).
- Fail to redirect: the fail is sampled at edge N; `redirect_o` and `squash_o` rise after edge N.
- `redirect_o` is high for exactly one cycle.
- `squash_o` is high for exactly `FLUSH_CYCLES` cycles, the first of which coincides with `redirect_o`.
- First push accepted after a fail: at edge N+`FLUSH_CYCLES`+1.
- `stall_o` is combinational from `count_o`==DEPTH; it falls the cycle after a pop or flush.
- Reset asserted mid-FLUSH: the next edge returns to IDLE with all outputs at reset values. No residual squash or redirect.
- Back-to-back fails are impossible: the queue is empty and resolves are ignored during `FLUSH`.

## Structure
- Shared package `branch_pkg`:
  - `recov_state_t` enum {`IDLE`, `FLUSH`}.
  - `PC_W` constant.
  - Default `FLUSH_CYCLES`.
  - PSW bit-index constants (C=0, Z=1, N=2, V=4), reused across the branch stages.
- Sub-module `bpred_fifo`: parameterised synchronous FIFO with `push`, `pop`, `clear`, `head`, `count`. Same-cycle `clear` beats `push`.
- `branch_recovery` contains the FSM, the flush counter, redirect latching and error tracking.

## Test plan
- Reset, then push 0x0102, 0x0206, 0x0310 → `count_o`=3. Three correct resolves → `count_o`=0, `redirect_o` never high, `error_o`=0.
- Push 0x0102 and 0x0206, then resolve with fail → next cycle `redirect_o`=1 for one cycle, `redirect_pc_o`=0x0102, `squash_o` high 2 cycles, `count_o`=0.
- Fill to 4 entries → `stall_o`=1. A 5th push is dropped and `count_o` stays 4. Same-cycle push+resolve → `count_o`=4 and the new tail equals the pushed PC.
- Resolve on empty → `error_o`=1 and stays high through later traffic until `rst_n`=0.
- Pushes and resolves during `FLUSH` → ignored; `count_o`=0 when IDLE is re-entered.
- Fail, then assert `rst_n`=0 on the first squash cycle → the next cycle has `squash_o`=0, `redirect_o`=0, state `IDLE`.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch pipeline stages.
package branch_pkg;
   typedef enum logic {IDLE, FLUSH} recov_state_t;

   localparam int PC_W             = 16;
   localparam int FLUSH_CYCLES_DEF = 2;

   // PSW flag bit positions, shared by the condition-evaluation stages
   localparam int PSW_C = 0;
   localparam int PSW_Z = 1;
   localparam int PSW_N = 2;
   localparam int PSW_V = 4;
endpackage

// File: rtl/bpred_fifo.sv
// Synchronous FIFO of fall-through PCs. Clear beats push; a push into a full
// queue is taken only when the head is popped in the same cycle.
module bpred_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   input  logic          clear,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !clear && do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/branch_recovery.sv
// Branch recovery: queues fall-through PCs, redirects fetch on a mispredict
// and squashes the wrong-path front end for FLUSH_CYCLES cycles.
module branch_recovery #(
   parameter  int DEPTH        = 4,
   parameter  int PC_W         = branch_pkg::PC_W,
   parameter  int FLUSH_CYCLES = branch_pkg::FLUSH_CYCLES_DEF,
   localparam int CW           = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_i,
   input  logic [PC_W-1:0] push_pc_i,
   input  logic            resolve_i,
   input  logic            branch_fail_i,
   output logic            stall_o,
   output logic            redirect_o,
   output logic [PC_W-1:0] redirect_pc_o,
   output logic            squash_o,
   output logic [CW-1:0]   count_o,
   output logic            error_o
);
   import branch_pkg::*;

   localparam int FW = $clog2(FLUSH_CYCLES) + 1;

   recov_state_t    state;
   logic [FW-1:0]   flush_cnt;
   logic [PC_W-1:0] head_pc;
   logic            idle, empty, fail;

   assign idle    = (state == IDLE);
   assign empty   = (count_o == '0);
   assign fail    = idle && resolve_i && branch_fail_i && !empty;
   assign stall_o = (count_o == CW'(DEPTH));

   bpred_fifo #(.DEPTH(DEPTH), .W(PC_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_i && idle),
      .din   (push_pc_i),
      .pop   (resolve_i && idle),
      .clear (fail),
      .head  (head_pc),
      .count (count_o)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         flush_cnt     <= '0;
         redirect_o    <= 1'b0;
         redirect_pc_o <= '0;
         squash_o      <= 1'b0;
         error_o       <= 1'b0;
      end else begin
         redirect_o <= 1'b0;
         case (state)
            IDLE: begin
               if (resolve_i && empty) error_o <= 1'b1;
               if (fail) begin
                  redirect_o    <= 1'b1;
                  redirect_pc_o <= head_pc;
                  squash_o      <= 1'b1;
                  flush_cnt     <= FW'(FLUSH_CYCLES - 1);
                  state         <= FLUSH;
               end
            end
            FLUSH: begin
               // Counter at zero marks the last squash cycle
               if (flush_cnt == '0) begin
                  squash_o <= 1'b0;
                  state    <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_branch_recovery.sv
// Directed plus randomized bench for branch_recovery against a queue model.
module tb_branch_recovery;
   localparam int DEPTH = 4;
   localparam int PC_W  = 16;
   localparam int FLUSH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n, push_i, resolve_i, branch_fail_i;
   logic [PC_W-1:0] push_pc_i;
   logic            stall_o, redirect_o, squash_o, error_o;
   logic [PC_W-1:0] redirect_pc_o;
   logic [CW-1:0]   count_o;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [PC_W-1:0] mq[$];
   int              m_left;
   logic            m_redir, m_err;
   logic [PC_W-1:0] m_rpc;

   branch_recovery #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYCLES(FLUSH)) dut (
      .clk(clk), .rst_n(rst_n), .push_i(push_i), .push_pc_i(push_pc_i),
      .resolve_i(resolve_i), .branch_fail_i(branch_fail_i), .stall_o(stall_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .squash_o(squash_o),
      .count_o(count_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic p, input logic [PC_W-1:0] pc,
                             input logic res, input logic f);
      int sz;
      if (!r) begin
         mq.delete(); m_left = 0; m_redir = 0; m_err = 0; m_rpc = '0;
      end else if (m_left > 0) begin
         m_redir = 0;
         m_left--;
      end else begin
         m_redir = 0;
         sz = mq.size();
         if (res && sz == 0) begin
            m_err = 1;
            if (p) mq.push_back(pc);
         end else if (res && f) begin
            m_rpc = mq[0];
            mq.delete();
            m_redir = 1;
            m_left = FLUSH;
         end else begin
            if (res) void'(mq.pop_front());
            if (p && (sz < DEPTH || res)) mq.push_back(pc);
         end
      end
   endtask

   task automatic step(input logic r, input logic p, input logic [PC_W-1:0] pc,
                       input logic res, input logic f);
      rst_n = r; push_i = p; push_pc_i = pc; resolve_i = res; branch_fail_i = f;
      @(posedge clk);
      model_edge(r, p, pc, res, f);
      #1;
      chk("count",    32'(count_o),      32'(mq.size()));
      chk("stall",    32'(stall_o),      32'(mq.size() == DEPTH));
      chk("redirect", 32'(redirect_o),   32'(m_redir));
      chk("squash",   32'(squash_o),     32'(m_left > 0));
      chk("error",    32'(error_o),      32'(m_err));
      chk("rpc",      32'(redirect_pc_o), 32'(m_rpc));
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1, 0, '0, 0, 0);
   endtask

   initial begin
      step(0, 0, '0, 0, 0);
      step(0, 0, '0, 0, 0);
      // explicit reset values
      chk("rst_count", 32'(count_o), 0);
      chk("rst_squash", 32'(squash_o), 0);

      // three pushes, three correct resolves
      step(1, 1, 16'h0102, 0, 0);
      step(1, 1, 16'h0206, 0, 0);
      step(1, 1, 16'h0310, 0, 0);
      chk("three_pushed", 32'(count_o), 3);
      for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0);
      chk("drained", 32'(count_o), 0);

      // mispredict with same-cycle push discarded
      step(1, 1, 16'h0102, 0, 0);
      step(1, 1, 16'h0206, 0, 0);
      step(1, 1, 16'h0aaa, 1, 1);
      chk("fail_pc", 32'(redirect_pc_o), 32'h0102);
      chk("fail_redirect", 32'(redirect_o), 1);
      idle_n(3);

      // fill, overflow, push+resolve while full, then check new tail
      for (int i = 0; i < 4; i++) step(1, 1, 16'(16'h1000 + 2 * i), 0, 0);
      chk("full_stall", 32'(stall_o), 1);
      step(1, 1, 16'h2222, 0, 0);
      chk("overflow_drop", 32'(count_o), 4);
      step(1, 1, 16'h4444, 1, 0);
      chk("full_pushpop", 32'(count_o), 4);
      for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0);
      step(1, 0, '0, 1, 1);
      chk("tail_pc", 32'(redirect_pc_o), 32'h4444);
      // traffic during flush is ignored
      step(1, 1, 16'h5555, 1, 0);
      idle_n(2);

      // resolve on empty sets sticky error
      step(1, 0, '0, 1, 0);
      chk("err_set", 32'(error_o), 1);
      step(1, 1, 16'h0600, 0, 0);
      step(1, 0, '0, 1, 0);
      chk("err_sticky", 32'(error_o), 1);

      // reset on first squash cycle
      step(1, 1, 16'h0700, 0, 0);
      step(1, 0, '0, 1, 1);
      step(0, 0, '0, 0, 0);
      chk("rst_flush_squash", 32'(squash_o), 0);
      chk("rst_flush_err", 32'(error_o), 0);
      step(1, 1, 16'h0800, 0, 0);
      chk("post_rst_push", 32'(count_o), 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, p, res, f;
         r   = ($urandom_range(0, 199) != 0);
         p   = ($urandom_range(0, 99) < 55);
         res = ($urandom_range(0, 99) < 40);
         f   = ($urandom_range(0, 99) < 25);
         step(r, p, 16'($urandom) & 16'hfffe, res, f);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
